// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one instruction-memory request at a time, buffers the
// returned word with its address, and hands it to decode over valid/ready.
module instr_fetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        redirect,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready,
    output logic        pc_stall
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_BLOCK = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] req_pc;
    logic        drop;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    logic        fire;
    logic        out_free;

    // A redirect gates the request so it can never coincide with a grant.
    assign imem_req  = (state == S_REQ) & ~redirect;
    assign imem_addr = pc;
    assign fire      = imem_req & imem_gnt;
    assign pc_stall  = ~(fire | redirect);
    assign out_free  = ~id_valid | id_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_REQ;
            req_pc     <= '0;
            drop       <= 1'b0;
            id_valid   <= 1'b0;
            id_instr   <= NOP_INSTR;
            id_pc      <= '0;
            skid_valid <= 1'b0;
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
        end else begin
            // NOTE: non-blocking updates mean the last assignment in this block
            // wins; the handshake clear comes first, loads override it, and the
            // redirect flush at the bottom overrides everything.
            if (id_valid & id_ready) begin
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end

            case (state)
                S_REQ: begin
                    if (fire) begin
                        req_pc <= pc;
                        drop   <= 1'b0;
                        state  <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop | redirect) begin
                            state <= S_REQ;
                        end else if (out_free) begin
                            id_valid <= 1'b1;
                            id_instr <= imem_rdata;
                            id_pc    <= req_pc;
                            state    <= S_REQ;
                        end else begin
                            skid_valid <= 1'b1;
                            skid_instr <= imem_rdata;
                            skid_pc    <= req_pc;
                            state      <= S_BLOCK;
                        end
                    end else if (redirect) begin
                        drop <= 1'b1;
                    end
                end

                S_BLOCK: begin
                    if (redirect) begin
                        state <= S_REQ;
                    end else if (id_ready) begin
                        id_valid   <= skid_valid;
                        id_instr   <= skid_instr;
                        id_pc      <= skid_pc;
                        skid_valid <= 1'b0;
                        state      <= S_REQ;
                    end
                end

                default: state <= S_REQ;
            endcase

            if (redirect) begin
                id_valid   <= 1'b0;
                id_instr   <= NOP_INSTR;
                skid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a simple PC model follows pc_stall,
// memory responses are driven cycle by cycle with hand-computed expectations.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        redirect;
    logic [31:0] target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
    logic        pc_stall;

    int tests;
    int fails;

    instr_fetch_unit #(.NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .redirect    (redirect),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_ready    (id_ready),
        .pc_stall    (pc_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter: advances only when the fetch unit releases the stall.
    always @(posedge clk or posedge reset) begin
        if (reset)
            pc <= 32'h0;
        else if (!pc_stall)
            pc <= redirect ? target : pc + 32'h4;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        id_ready    = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        tests       = 0;
        fails       = 0;
        target      = 32'h0;
        reset       = 1'b1;
        redirect    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        id_ready    = 1'b1;
        settle();

        // ---- reset values ----
        check("rst_id_valid", id_valid, 0);
        check("rst_id_instr", id_instr, NOP);
        check("rst_id_pc", id_pc, 0);
        check("rst_imem_req", imem_req, 1);
        check("rst_pc_stall", pc_stall, 1);
        cyc();
        reset = 1'b0;

        // ---- stream 0x0, 0x4, 0x8 with 1-cycle memory ----
        imem_gnt = 1'b1; settle();
        check("s1_addr0", imem_addr, 32'h0);
        check("s1_stall_gnt0", pc_stall, 0);
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0000; settle();
        check("s1_req_wait", imem_req, 0);
        check("s1_stall_wait", pc_stall, 1);
        check("s1_valid_wait", id_valid, 0);
        cyc();
        imem_rvalid = 1'b0; imem_gnt = 1'b1; settle();
        check("s1_valid0", id_valid, 1);
        check("s1_pc0", id_pc, 32'h0);
        check("s1_instr0", id_instr, 32'hA000_0000);
        check("s1_addr4", imem_addr, 32'h4);
        check("s1_stall_gnt4", pc_stall, 0);
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0004; settle();
        check("s1_gap", id_valid, 0);
        cyc();
        imem_rvalid = 1'b0; imem_gnt = 1'b1; settle();
        check("s1_pc4", id_pc, 32'h4);
        check("s1_instr4", id_instr, 32'hA000_0004);
        check("s1_addr8", imem_addr, 32'h8);
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0008;
        cyc();
        imem_rvalid = 1'b0; settle();
        check("s1_valid8", id_valid, 1);
        check("s1_pc8", id_pc, 32'h8);

        // ---- decode backpressure, then redirect in WAIT ----
        do_reset();
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0000;
        cyc();
        imem_rvalid = 1'b0; imem_gnt = 1'b1; id_ready = 1'b0; settle();
        check("bp_pc0", id_pc, 32'h0);
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0004;
        cyc();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_req_block", imem_req, 0);
            check("bp_hold_pc", id_pc, 32'h0);
            check("bp_hold_instr", id_instr, 32'hA000_0000);
            check("bp_hold_valid", id_valid, 1);
            check("bp_stall", pc_stall, 1);
            cyc();
        end
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0; imem_gnt = 1'b1; settle();
        check("bp_skid_pc", id_pc, 32'h4);
        check("bp_skid_instr", id_instr, 32'hA000_0004);
        check("bp_req_after", imem_req, 1);
        check("bp_addr8", imem_addr, 32'h8);
        cyc();
        imem_gnt = 1'b0; settle();
        check("rw_hold_valid", id_valid, 1);
        redirect = 1'b1; target = 32'h100; settle();
        check("rw_stall", pc_stall, 0);
        check("rw_req", imem_req, 0);
        cyc();
        redirect = 1'b0; settle();
        check("rw_flush_valid", id_valid, 0);
        check("rw_flush_instr", id_instr, NOP);
        check("rw_pc_target", pc, 32'h100);
        cyc();
        imem_rvalid = 1'b1; imem_rdata = 32'hA000_0008; settle();
        check("rw_still_wait", imem_req, 0);
        cyc();
        imem_rvalid = 1'b0; id_ready = 1'b1; settle();
        check("rw_discard", id_valid, 0);
        check("rw_req_next", imem_req, 1);
        check("rw_addr_tgt", imem_addr, 32'h100);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0100;
        cyc();
        imem_rvalid = 1'b0; settle();
        check("rw_valid_tgt", id_valid, 1);
        check("rw_pc_tgt", id_pc, 32'h100);
        check("rw_instr_tgt", id_instr, 32'hA000_0100);

        // ---- redirect in BLOCK ----
        do_reset();
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0000;
        cyc();
        imem_rvalid = 1'b0; imem_gnt = 1'b1; id_ready = 1'b0;
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0004;
        cyc();
        imem_rvalid = 1'b0; redirect = 1'b1; target = 32'h200; settle();
        check("rb_req", imem_req, 0);
        check("rb_stall", pc_stall, 0);
        cyc();
        redirect = 1'b0; id_ready = 1'b1; settle();
        check("rb_valid", id_valid, 0);
        check("rb_instr", id_instr, NOP);
        check("rb_req_next", imem_req, 1);
        check("rb_addr", imem_addr, 32'h200);
        cyc();
        settle();
        check("rb_no_skid", id_valid, 0);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0200;
        cyc();
        imem_rvalid = 1'b0; settle();
        check("rb_pc_tgt", id_pc, 32'h200);
        check("rb_instr_tgt", id_instr, 32'hA000_0200);

        // ---- grant latency of 4 cycles ----
        do_reset();
        for (int i = 0; i < 4; i++) begin
            settle();
            check("gl_stall", pc_stall, 1);
            check("gl_req", imem_req, 1);
            check("gl_pc", pc, 32'h0);
            cyc();
        end
        imem_gnt = 1'b1;
        cyc();
        for (int i = 0; i < 2; i++) begin
            settle();
            check("gl_one_req", imem_req, 0);
            check("gl_pc_once", pc, 32'h4);
            cyc();
        end
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA000_0000;
        cyc();
        imem_rvalid = 1'b0; id_ready = 1'b0; settle();
        check("gl_pc0", id_pc, 32'h0);
        check("gl_valid0", id_valid, 1);

        // ---- async reset mid-WAIT ----
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0; settle();
        check("ar_pre_wait", imem_req, 0);
        check("ar_pre_valid", id_valid, 1);
        reset = 1'b1; settle();
        check("ar_valid", id_valid, 0);
        check("ar_instr", id_instr, NOP);
        check("ar_req", imem_req, 1);
        check("ar_stall", pc_stall, 1);
        cyc();
        reset = 1'b0; id_ready = 1'b1; settle();
        check("ar_req_after", imem_req, 1);
        check("ar_addr_after", imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
